cbd_sampler: RTL and testbench

Streaming centered-binomial-distribution sampler for the pqcrypto accelerator. It consumes uniformly random words from the PRF/XOF stream and emits one polynomial of N_COEF coefficients reduced mod Q. Each coefficient is computed as HW(a) − HW(b) over eta-bit fields, with eta = 2 or 3 selected per polynomial. It is the parametrised, sequential successor to the 4-bit Hamming-weight LUT: popcount width tracks eta, and it adds a bit buffer, stream handshakes and a coefficient counter.

---
 rtl/cbd_sampler.sv | 223 ++++++++++++++++++++++
 tb/tb_cbd_sampler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_sampler.sv
// ---------------------------------------------------------------------------
// cbd_sampler
//
// Streaming centered-binomial sampler. Uniform random words are appended to
// a 2*DATA_W bit buffer, LSB first. Each coefficient takes the low 2*eta bits
// of the buffer: a = low eta bits, b = next eta bits, and
// coef = HW(a) - HW(b), reduced into [0, Q). eta is 2 or 3, chosen per
// polynomial when the start is accepted.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   start_i        begin a polynomial (only honoured in IDLE)
//   eta3_i         0: eta=2, 1: eta=3 (sampled with an accepted start)
//   busy_o         high while a polynomial is in progress
//   done_o         one-cycle pulse after the last coefficient handshake
//   rnd_valid_i    random word valid
//   rnd_ready_o    sampler accepts a random word
//   rnd_data_i     random word
//   coef_valid_o   coefficient valid
//   coef_ready_i   consumer accepts the coefficient
//   coef_o         coefficient in [0, Q)
//   coef_idx_o     index of the coefficient on coef_o
//
// States
//   state  | meaning
//   S_IDLE | waiting for start_i; no words accepted, no coefficients issued
//   S_RUN  | sampling; ends on the handshake of coefficient N_COEF-1
// ---------------------------------------------------------------------------
module cbd_sampler #(
    parameter int DATA_W = 32,
    parameter int N_COEF = 256,
    parameter int Q      = 3329,
    parameter int COEF_W = 12,
    parameter int IDX_W  = $clog2(N_COEF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              eta3_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              rnd_valid_i,
    output logic              rnd_ready_o,
    input  logic [DATA_W-1:0] rnd_data_i,
    output logic              coef_valid_o,
    input  logic              coef_ready_i,
    output logic [COEF_W-1:0] coef_o,
    output logic [IDX_W-1:0]  coef_idx_o
);

    localparam int BUF_W      = 2 * DATA_W;
    localparam int CNT_W      = $clog2(BUF_W + 1);
    localparam int WORDS_ETA2 = (N_COEF * 4) / DATA_W;
    localparam int WORDS_ETA3 = (N_COEF * 6) / DATA_W;
    localparam int WCNT_W     = $clog2(WORDS_ETA3 + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_eta3;
    logic [BUF_W-1:0]    r_buf;
    logic [CNT_W-1:0]    r_cnt;
    logic [WCNT_W-1:0]   r_words;
    logic                r_coef_valid;
    logic [COEF_W-1:0]   r_coef;
    logic [IDX_W-1:0]    r_idx;
    logic                r_done;

    logic                w_run;
    logic                w_start_acc;
    logic                w_rnd_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;
    logic                w_last_hs;
    logic [CNT_W-1:0]    w_field_bits;
    logic [WCNT_W-1:0]   w_word_limit;
    logic [BUF_W-1:0]    w_buf_shifted;
    logic [CNT_W-1:0]    w_push_base;
    logic [BUF_W-1:0]    w_buf_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [2:0]          w_field_a;
    logic [2:0]          w_field_b;
    logic [2:0]          w_diff;
    logic [2:0]          w_diff_mag;
    logic [COEF_W-1:0]   w_coef_val;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    assign w_run        = (r_state == S_RUN);
    assign w_start_acc  = (r_state == S_IDLE) && start_i;
    assign w_field_bits = r_eta3 ? CNT_W'(6) : CNT_W'(4);
    assign w_word_limit = r_eta3 ? WCNT_W'(WORDS_ETA3) : WCNT_W'(WORDS_ETA2);

    // Only registered terms, so there is no path from coef_ready_i. The word
    // limit is exact, which guarantees the buffer drains to zero at the end.
    assign w_rnd_ready  = w_run && (r_cnt <= CNT_W'(DATA_W)) && (r_words < w_word_limit);
    assign w_push       = rnd_valid_i && w_rnd_ready;
    assign w_hs         = r_coef_valid && coef_ready_i;
    assign w_last_hs    = w_hs && (r_idx == IDX_W'(N_COEF - 1));

    // Output register loads when a full field is buffered and the register
    // is either empty or being emptied in this same cycle.
    assign w_pop        = w_run && (r_cnt >= w_field_bits) && (!r_coef_valid || coef_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_state_next = S_RUN;
            S_RUN:  if (w_last_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit buffer: pop shifts out the low field first, then the new word lands
    // directly above whatever bits remain.
    // -----------------------------------------------------------------------
    always_comb begin
        w_buf_shifted = r_buf;
        w_push_base   = r_cnt;
        w_buf_next    = r_buf;
        w_cnt_next    = r_cnt;
        if (w_pop) begin
            w_buf_shifted = r_buf >> w_field_bits;
            w_push_base   = r_cnt - w_field_bits;
        end
        w_buf_next = w_buf_shifted;
        if (w_push) begin
            w_buf_next = w_buf_shifted | ({{DATA_W{1'b0}}, rnd_data_i} << w_push_base);
        end
        w_cnt_next = w_push_base + (w_push ? CNT_W'(DATA_W) : CNT_W'(0));
    end

    // -----------------------------------------------------------------------
    // Coefficient arithmetic. For eta=2 the top bit of each 3-bit field is
    // forced to zero so one popcount serves both widths. The 3-bit difference
    // covers [-3, 3]; a negative result wraps to Q - |diff|.
    // -----------------------------------------------------------------------
    always_comb begin
        w_field_a  = r_eta3 ? r_buf[2:0] : {1'b0, r_buf[1:0]};
        w_field_b  = r_eta3 ? r_buf[5:3] : {1'b0, r_buf[3:2]};
        w_diff     = {1'b0, popcnt3(w_field_a)} - {1'b0, popcnt3(w_field_b)};
        w_diff_mag = 3'd0 - w_diff;
        if (w_diff[2]) begin
            w_coef_val = COEF_W'(Q) - COEF_W'(w_diff_mag);
        end else begin
            w_coef_val = COEF_W'(w_diff);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_eta3       <= 1'b0;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_words      <= '0;
            r_coef_valid <= 1'b0;
            r_coef       <= '0;
            r_idx        <= '0;
        end else if (w_start_acc) begin
            r_eta3       <= eta3_i;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_words      <= '0;
            r_coef_valid <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            if (w_push) begin
                r_words <= r_words + WCNT_W'(1);
            end
            if (w_pop) begin
                r_coef       <= w_coef_val;
                r_coef_valid <= 1'b1;
            end else if (w_hs) begin
                r_coef_valid <= 1'b0;
            end
            if (w_hs) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_hs;
        end
    end

    assign busy_o       = w_run;
    assign done_o       = r_done;
    assign rnd_ready_o  = w_rnd_ready;
    assign coef_valid_o = r_coef_valid;
    assign coef_o       = r_coef;
    assign coef_idx_o   = r_idx;

endmodule

// File: tb/tb_cbd_sampler.sv
module tb_cbd_sampler;

    localparam int DATA_W = 32;
    localparam int N_COEF = 256;
    localparam int Q      = 3329;
    localparam int COEF_W = 12;
    localparam int IDX_W  = 8;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic              eta3_i;
    logic              busy_o;
    logic              done_o;
    logic              rnd_valid_i;
    logic              rnd_ready_o;
    logic [DATA_W-1:0] rnd_data_i;
    logic              coef_valid_o;
    logic              coef_ready_i;
    logic [COEF_W-1:0] coef_o;
    logic [IDX_W-1:0]  coef_idx_o;

    always #5 clk = ~clk;

    cbd_sampler #(
        .DATA_W(DATA_W), .N_COEF(N_COEF), .Q(Q), .COEF_W(COEF_W), .IDX_W(IDX_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .eta3_i(eta3_i),
        .busy_o(busy_o), .done_o(done_o),
        .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o), .rnd_data_i(rnd_data_i),
        .coef_valid_o(coef_valid_o), .coef_ready_i(coef_ready_i),
        .coef_o(coef_o), .coef_idx_o(coef_idx_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Model state: random stream, expected coefficients, observed results.
    logic [DATA_W-1:0] words [48];
    int  exp_coef [N_COEF];
    int  dut_coef [N_COEF];
    int  ref_coef [N_COEF];
    int  fb, exp_words;
    int  hs_count, words_acc, done_count;
    bit  chk_en = 1'b0;
    bit  started;
    bit  stall_prev, prev_last_hs;
    int  prev_coef, prev_idx;
    int  cnt_m;
    bit  run_m;

    function automatic int bit_at(input int pos);
        logic [DATA_W-1:0] w;
        w = words[pos / DATA_W];
        return int'(w[pos % DATA_W]);
    endfunction

    // Expected polynomial straight from the sampling rule on the concatenated
    // bit stream (bit k*2*eta is the first bit of coefficient k).
    task automatic setup(input bit e3);
        int eta, a, b;
        eta       = e3 ? 3 : 2;
        fb        = 2 * eta;
        exp_words = N_COEF * fb / DATA_W;
        for (int k = 0; k < N_COEF; k++) begin
            a = 0;
            b = 0;
            for (int j = 0; j < eta; j++) begin
                a += bit_at(k * fb + j);
                b += bit_at(k * fb + eta + j);
            end
            exp_coef[k] = (a - b >= 0) ? (a - b) : (Q + a - b);
            dut_coef[k] = -1;
        end
        hs_count     = 0;
        words_acc    = 0;
        done_count   = 0;
        stall_prev   = 1'b0;
        prev_last_hs = 1'b0;
        started      = 1'b0;
        chk_en       = 1'b1;
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cnt_m = words_acc * DATA_W - (hs_count + (coef_valid_o ? 1 : 0)) * fb;
            run_m = started && (hs_count < N_COEF);
            chk("busy", longint'(busy_o), longint'(run_m));
            chk("rnd_ready", longint'(rnd_ready_o),
                longint'(run_m && (cnt_m <= DATA_W) && (words_acc < exp_words)));
            chk("done", longint'(done_o), longint'(prev_last_hs));
            if (stall_prev) begin
                chk("hold_valid", longint'(coef_valid_o), 1);
                chk("hold_coef", longint'(coef_o), prev_coef);
                chk("hold_idx", longint'(coef_idx_o), prev_idx);
            end
            prev_last_hs = 1'b0;
            if (coef_valid_o && coef_ready_i) begin
                if (hs_count < N_COEF) begin
                    chk("coef_idx", longint'(coef_idx_o), hs_count);
                    chk("coef_val", longint'(coef_o), exp_coef[hs_count]);
                    dut_coef[hs_count] = int'(coef_o);
                    prev_last_hs = (hs_count == N_COEF - 1);
                end else begin
                    chk("extra_coef", hs_count, N_COEF - 1);
                end
                hs_count++;
            end
            if (rnd_valid_i && rnd_ready_o) words_acc++;
            if (done_o) done_count++;
            stall_prev = coef_valid_o && !coef_ready_i;
            prev_coef  = int'(coef_o);
            prev_idx   = int'(coef_idx_o);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  longint'(busy_o), 0);
        chk({tag, "_done"},  longint'(done_o), 0);
        chk({tag, "_ready"}, longint'(rnd_ready_o), 0);
        chk({tag, "_valid"}, longint'(coef_valid_o), 0);
        chk({tag, "_coef"},  longint'(coef_o), 0);
        chk({tag, "_idx"},   longint'(coef_idx_o), 0);
    endtask

    // One polynomial. Starts it (unless a start was already issued in the
    // previous done cycle), feeds words, applies stalls/perturbation/abort.
    task automatic run_poly(input bit e3, input int gap, input int stall_at,
                            input bit perturb, input int abort_at,
                            input bit chain, input bit chain_e3, input bit prestarted);
        int widx, cyc, first_acc, first_val, stall_left;
        bit stalled, seen_done;
        if (!prestarted) begin
            setup(e3);
            @(posedge clk); #1;
            start_i      = 1'b1;
            eta3_i       = e3;
            coef_ready_i = 1'b1;
            rnd_valid_i  = 1'b0;
            @(posedge clk); #1;
            start_i = 1'b0;
            started = 1'b1;
            chk("start_busy", longint'(busy_o), 1);
            chk("start_ready", longint'(rnd_ready_o), 1);
        end
        widx = 0; cyc = 0; first_acc = -1; first_val = -1;
        stall_left = 0; stalled = 1'b0; seen_done = 1'b0;
        while (!seen_done && cyc < 4000) begin
            if (abort_at >= 0 && hs_count >= abort_at) begin
                chk_en       = 1'b0;
                rst_ni       = 1'b0;
                start_i      = 1'b0;
                rnd_valid_i  = 1'b0;
                coef_ready_i = 1'b0;
                @(posedge clk); #1;
                chk_reset_vals("midrst");
                rst_ni = 1'b1;
                return;
            end
            if (stall_at >= 0 && !stalled && hs_count >= stall_at) begin
                stall_left = 10;
                stalled    = 1'b1;
            end
            coef_ready_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            rnd_valid_i = (widx < exp_words) && (int'($urandom_range(99)) >= gap);
            rnd_data_i  = (widx < exp_words) ? words[widx] : $urandom;
            start_i     = perturb && cyc >= 20 && cyc < 26;
            eta3_i      = (perturb && cyc >= 18 && cyc < 30) ? ~e3 : e3;
            @(negedge clk);
            if (rnd_valid_i && rnd_ready_o) begin
                if (first_acc < 0) first_acc = cyc;
                widx++;
            end
            if (coef_valid_o && first_val < 0) first_val = cyc;
            if (done_o) begin
                seen_done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_seen", longint'(seen_done), 1);
        if (chain) begin
            start_i = 1'b1;
            eta3_i  = chain_e3;
        end else begin
            start_i = 1'b0;
        end
        @(posedge clk); #1;
        chk("hs_total", hs_count, N_COEF);
        chk("words_total", words_acc, exp_words);
        chk("done_pulses", done_count, 1);
        chk("first_latency", first_val, first_acc + 2);
        chk("done_width", longint'(done_o), 0);
        if (chain) begin
            start_i = 1'b0;
            setup(chain_e3);
            started = 1'b1;
            chk("chain_busy", longint'(busy_o), 1);
            chk("chain_ready", longint'(rnd_ready_o), 1);
        end
    endtask

    initial begin
        int ndiff, nz;
        rst_ni = 1'b0; start_i = 1'b0; eta3_i = 1'b0;
        rnd_valid_i = 1'b0; rnd_data_i = '0; coef_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_ni = 1'b1;

        // eta=2, all-zero stream
        for (int i = 0; i < 48; i++) words[i] = '0;
        run_poly(1'b0, 0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        // eta=2 values and mod-Q wrap
        words[0] = 32'h0000_00C3;
        run_poly(1'b0, 0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        chk("model_c0", exp_coef[0], 2);
        chk("model_c1", exp_coef[1], 3327);
        chk("eta2_c0", dut_coef[0], 2);
        chk("eta2_c1", dut_coef[1], 3327);
        for (int k = 2; k < 8; k++) chk("eta2_c2to7", dut_coef[k], 0);

        // eta=3 field straddling the word boundary
        words[0] = 32'hC000_0007;
        run_poly(1'b1, 0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        chk("model_e3_c0", exp_coef[0], 3);
        chk("model_e3_c5", exp_coef[5], 2);
        chk("eta3_c0", dut_coef[0], 3);
        chk("eta3_c5", dut_coef[5], 2);
        nz = 0;
        for (int k = 1; k < N_COEF; k++) if (k != 5 && dut_coef[k] != 0) nz++;
        chk("eta3_others_zero", nz, 0);

        // Backpressure with random input gaps vs. an unstalled run
        for (int i = 0; i < 48; i++) words[i] = $urandom;
        run_poly(1'b0, 0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N_COEF; k++) ref_coef[k] = dut_coef[k];
        run_poly(1'b0, 30, 50, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        ndiff = 0;
        for (int k = 0; k < N_COEF; k++) if (dut_coef[k] != ref_coef[k]) ndiff++;
        chk("stall_vs_plain", ndiff, 0);
        run_poly(1'b1, 40, 120, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        // Ignored start/eta toggles during RUN
        run_poly(1'b1, 20, -1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        run_poly(1'b0, 10, -1, 1'b1, -1, 1'b0, 1'b0, 1'b0);

        // Reset after 100 handshakes, then a complete fresh polynomial
        run_poly(1'b1, 15, -1, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        run_poly(1'b1, 15, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        // Start issued in the done cycle, eta changes between polynomials
        run_poly(1'b0, 0, -1, 1'b0, -1, 1'b1, 1'b1, 1'b0);
        run_poly(1'b1, 25, 30, 1'b0, -1, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
